// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word requests under a credit
// limit, buffers tagged responses and presents the head with decoded fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_fault
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CW-1:0] count, outstanding, drop;
  logic          fault;

  logic          req_fire, push, pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Stale responses (drop != 0) and responses in a redirect cycle never reach
  // the buffer; stale ones still hold a credit until they drain.
  assign credit_used     = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid  = !rst && !fault && (credit_used < (CW + 1)'(DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign inst_valid      = !rst && (count != '0);
  assign pop             = inst_valid && inst_ready;
  assign push            = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fault       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        fault    <= |redirect_pc[1:0];
        drop     <= outstanding_nxt;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= ptr_inc(tag_wr);
        end
        if (imem_rsp_valid && (drop != '0))
          drop <= drop - 1'b1;
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          tag_rd <= ptr_inc(tag_rd);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire && !redirect_valid)
      tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
      fifo_word[wr_ptr] <= imem_rsp_data;
    end
  end

  assign inst_pc     = rst ? '0 : fifo_pc[rd_ptr];
  assign inst_word   = rst ? '0 : fifo_word[rd_ptr];
  assign opcode      = inst_word[6:0];
  assign funct3      = inst_word[14:12];
  assign funct7      = inst_word[31:25];
  assign fetch_fault = fault;

endmodule
